// File: rtl/dose_schedule_reader.sv
// Scans the RAM1 frequency table on each timer tick, counts per-medicine intervals down and raises sticky due flags.
// Optional missed-dose counter enabled by defining DOSE_MISSED_COUNT_EN.
module dose_schedule_reader #(
  parameter int unsigned ID_W   = 2,
  parameter int unsigned FREQ_W = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Tick,
  output logic                    R_en,
  output logic [ID_W-1:0]         R_addr,
  input  logic [FREQ_W-1:0]       R_data,
  input  logic                    Ack,
  input  logic [ID_W-1:0]         AckId,
  output logic [(1<<ID_W)-1:0]    DueMask,
  output logic                    AnyDue,
  output logic                    Busy,
  output logic                    ScanDone,
  output logic [3:0]              MissCount
);

  localparam int unsigned NUM_MEDS = 1 << ID_W;
  localparam logic [ID_W-1:0] LAST_SLOT = ID_W'(NUM_MEDS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   slot_q, slot_d;
  logic              pending_q, pending_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [FREQ_W-1:0] cnt_q [NUM_MEDS];
  logic [FREQ_W-1:0] cnt_d [NUM_MEDS];
  logic [NUM_MEDS-1:0] due_d;
  logic              ren_d, busy_d, done_d;
  logic [ID_W-1:0]   addr_d;

  // Next-state, countdown update and registered-output next values
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    pending_d = pending_q;
    freq_d    = freq_q;
    cnt_d     = cnt_q;
    due_d     = DueMask;
    addr_d    = R_addr;

    // Ack is applied first so a same-cycle set overrides it
    if (Ack) due_d[AckId] = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Tick || pending_q) begin
          state_d   = S_READ;
          slot_d    = '0;
          pending_d = 1'b0;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        freq_d  = R_data;
        state_d = S_UPDATE;
      end
      default: begin
        if (freq_q == '0) begin
          cnt_d[slot_q] = '0;
        end else if (cnt_q[slot_q] == '0) begin
          cnt_d[slot_q] = freq_q;
        end else if (cnt_q[slot_q] == FREQ_W'(1)) begin
          due_d[slot_q] = 1'b1;
          cnt_d[slot_q] = freq_q;
        end else begin
          cnt_d[slot_q] = cnt_q[slot_q] - FREQ_W'(1);
        end
        if (slot_q == LAST_SLOT) begin
          state_d = S_IDLE;
        end else begin
          slot_d  = slot_q + ID_W'(1);
          state_d = S_READ;
        end
      end
    endcase

    // A single tick is remembered while a scan runs; extras are dropped
    if (Tick && (state_q != S_IDLE)) pending_d = 1'b1;

    ren_d  = (state_d == S_READ);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_UPDATE) && (slot_d == LAST_SLOT);
    if (ren_d) addr_d = slot_d;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      pending_q <= 1'b0;
      freq_q    <= '0;
      cnt_q     <= '{default: '0};
      R_en      <= 1'b0;
      R_addr    <= '0;
      DueMask   <= '0;
      AnyDue    <= 1'b0;
      Busy      <= 1'b0;
      ScanDone  <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      pending_q <= pending_d;
      freq_q    <= freq_d;
      cnt_q     <= cnt_d;
      R_en      <= ren_d;
      R_addr    <= addr_d;
      DueMask   <= due_d;
      AnyDue    <= |due_d;
      Busy      <= busy_d;
      ScanDone  <= done_d;
    end
  end

`ifdef DOSE_MISSED_COUNT_EN
  logic miss_inc_c;

  // A re-set of a still-pending due flag is a missed dose
  assign miss_inc_c = (state_q == S_UPDATE) && (freq_q != '0) &&
                      (cnt_q[slot_q] == FREQ_W'(1)) && DueMask[slot_q] &&
                      !(Ack && (AckId == slot_q));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      MissCount <= 4'd0;
    end else if (miss_inc_c && (MissCount != 4'hF)) begin
      MissCount <= MissCount + 4'd1;
    end
  end
`else
  assign MissCount = 4'd0;
`endif

endmodule

// File: tb/tb_dose_schedule_reader.sv
// Directed self-checking bench for dose_schedule_reader with a one-cycle-latency RAM1 model.
module tb_dose_schedule_reader;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Tick;
  logic       R_en;
  logic [1:0] R_addr;
  logic [3:0] R_data = 4'd0;
  logic       Ack;
  logic [1:0] AckId;
  logic [3:0] DueMask;
  logic       AnyDue;
  logic       Busy;
  logic       ScanDone;
  logic [3:0] MissCount;

  logic [3:0] mem [4];
  int checks   = 0;
  int failures = 0;

  dose_schedule_reader #(.ID_W(2), .FREQ_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .R_en(R_en), .R_addr(R_addr),
    .R_data(R_data), .Ack(Ack), .AckId(AckId), .DueMask(DueMask),
    .AnyDue(AnyDue), .Busy(Busy), .ScanDone(ScanDone), .MissCount(MissCount)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (R_en) R_data <= mem[R_addr];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_mem(input logic [3:0] f0, input logic [3:0] f1,
                         input logic [3:0] f2, input logic [3:0] f3);
    mem[0] = f0; mem[1] = f1; mem[2] = f2; mem[3] = f3;
  endtask

  // One tick, then wait for the scan to finish; returns one cycle after ScanDone
  task automatic run_scan(input string name);
    bit seen;
    seen = 1'b0;
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (ScanDone) seen = 1'b1;
      else step();
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL %s_scandone_timeout: got seen=%b expected 1", name, seen);
    end
    step();
  endtask

  task automatic test_reset();
    Rst = 1'b0; Tick = 1'b0; Ack = 1'b0; AckId = 2'd0;
    #3;
    checks++; if (R_en !== 1'b0) begin failures++; $display("FAIL reset_r_en: got %b expected 0", R_en); end
    checks++; if (R_addr !== 2'd0) begin failures++; $display("FAIL reset_r_addr: got %0d expected 0", R_addr); end
    checks++; if (DueMask !== 4'b0000) begin failures++; $display("FAIL reset_duemask: got %b expected 0000", DueMask); end
    checks++; if (AnyDue !== 1'b0) begin failures++; $display("FAIL reset_anydue: got %b expected 0", AnyDue); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (ScanDone !== 1'b0) begin failures++; $display("FAIL reset_scandone: got %b expected 0", ScanDone); end
    checks++; if (MissCount !== 4'd0) begin failures++; $display("FAIL reset_misscount: got %0d expected 0", MissCount); end
    step();
    Rst = 1'b1;
    step();
  endtask

  task automatic test_schedule();
    logic [3:0] exp_mask [4];
    exp_mask[0] = 4'b0000; exp_mask[1] = 4'b0010;
    exp_mask[2] = 4'b1010; exp_mask[3] = 4'b1011;
    set_mem(4'd3, 4'd1, 4'd0, 4'd2);
    for (int t = 0; t < 4; t++) begin
      run_scan("schedule");
      checks++;
      if (DueMask !== exp_mask[t]) begin
        failures++;
        $display("FAIL schedule_tick%0d_duemask: got %b expected %b", t + 1, DueMask, exp_mask[t]);
      end
      checks++;
      if (AnyDue !== (exp_mask[t] != 4'b0000)) begin
        failures++;
        $display("FAIL schedule_tick%0d_anydue: got %b expected %b", t + 1, AnyDue, exp_mask[t] != 4'b0000);
      end
      step();
    end
  endtask

  // Tick in cycle n; k is the cycle offset from n
  task automatic test_timing();
    logic       e_ren, e_busy, e_done;
    logic [1:0] e_addr;
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      e_ren  = (k == 1) || (k == 4) || (k == 7) || (k == 10);
      e_busy = (k <= 12);
      e_done = (k == 12);
      e_addr = (k >= 10) ? 2'd3 : 2'((k - 1) / 3);
      checks++;
      if (R_en !== e_ren) begin failures++; $display("FAIL timing_r_en_k%0d: got %b expected %b", k, R_en, e_ren); end
      checks++;
      if (R_addr !== e_addr) begin failures++; $display("FAIL timing_r_addr_k%0d: got %0d expected %0d", k, R_addr, e_addr); end
      checks++;
      if (Busy !== e_busy) begin failures++; $display("FAIL timing_busy_k%0d: got %b expected %b", k, Busy, e_busy); end
      checks++;
      if (ScanDone !== e_done) begin failures++; $display("FAIL timing_scandone_k%0d: got %b expected %b", k, ScanDone, e_done); end
      step();
    end
    checks++;
    if (DueMask !== 4'b1011) begin failures++; $display("FAIL timing_duemask: got %b expected 1011", DueMask); end
  endtask

  task automatic test_ack_collision();
    bit idle;
    step();
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    repeat (5) step();
    Ack = 1'b1; AckId = 2'd1;
    step();
    Ack = 1'b0;
    checks++;
    if (DueMask[1] !== 1'b1) begin failures++; $display("FAIL ack_set_collision: got %b expected 1", DueMask[1]); end
    idle = 1'b0;
    for (int k = 0; k < 20 && !idle; k++) begin
      if (!Busy) idle = 1'b1;
      else step();
    end
    checks++;
    if (idle !== 1'b1) begin failures++; $display("FAIL ack_scan_end_timeout: got %b expected 1", idle); end
    checks++;
    if (DueMask !== 4'b1011) begin failures++; $display("FAIL ack_after_scan: got %b expected 1011", DueMask); end
    Ack = 1'b1; AckId = 2'd1; step(); Ack = 1'b0;
    checks++;
    if (DueMask !== 4'b1001) begin failures++; $display("FAIL ack_idle_slot1: got %b expected 1001", DueMask); end
    Ack = 1'b1; AckId = 2'd0; step(); Ack = 1'b0;
    checks++;
    if (DueMask !== 4'b1000) begin failures++; $display("FAIL ack_idle_slot0: got %b expected 1000", DueMask); end
    checks++;
    if (AnyDue !== 1'b1) begin failures++; $display("FAIL ack_anydue_still: got %b expected 1", AnyDue); end
    Ack = 1'b1; AckId = 2'd3; step(); Ack = 1'b0;
    checks++;
    if (DueMask !== 4'b0000) begin failures++; $display("FAIL ack_idle_slot3: got %b expected 0000", DueMask); end
    checks++;
    if (AnyDue !== 1'b0) begin failures++; $display("FAIL ack_anydue_clear: got %b expected 0", AnyDue); end
  endtask

  // Ticks at n, n+3 and n+6: one extra scan only, restarting at n+14
  task automatic test_pending();
    int n_ren, n_done, restart_k;
    n_ren = 0; n_done = 0; restart_k = -1;
    step();
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (R_en) n_ren++;
      if (ScanDone) n_done++;
      if (R_en && (R_addr == 2'd0) && (k > 1) && (restart_k < 0)) restart_k = k;
      Tick = (k == 3) || (k == 6);
      step();
    end
    Tick = 1'b0;
    checks++;
    if (n_ren !== 8) begin failures++; $display("FAIL pending_r_en_count: got %0d expected 8", n_ren); end
    checks++;
    if (n_done !== 2) begin failures++; $display("FAIL pending_scandone_count: got %0d expected 2", n_done); end
    checks++;
    if (restart_k !== 14) begin failures++; $display("FAIL pending_restart_cycle: got %0d expected 14", restart_k); end
  endtask

  task automatic test_reset_midscan();
    step();
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    repeat (7) step();
    #2;
    Rst = 1'b0;
    #1;
    checks++;
    if ({R_en, R_addr, DueMask, AnyDue, Busy, ScanDone, MissCount} !== 15'd0) begin
      failures++;
      $display("FAIL midscan_reset_outputs: got %b expected all 0",
               {R_en, R_addr, DueMask, AnyDue, Busy, ScanDone, MissCount});
    end
    step();
    Rst = 1'b1;
    step();
    set_mem(4'd3, 4'd1, 4'd0, 4'd2);
    run_scan("post_reset1");
    checks++;
    if (DueMask !== 4'b0000) begin failures++; $display("FAIL post_reset_first_tick: got %b expected 0000", DueMask); end
    step();
    run_scan("post_reset2");
    checks++;
    if (DueMask !== 4'b0010) begin failures++; $display("FAIL post_reset_second_tick: got %b expected 0010", DueMask); end
  endtask

  task automatic test_miss_count();
    logic [3:0] e_miss;
    Rst = 1'b0;
    step();
    Rst = 1'b1;
    step();
    set_mem(4'd1, 4'd0, 4'd0, 4'd0);
    for (int t = 1; t <= 20; t++) begin
      run_scan("miss");
`ifdef DOSE_MISSED_COUNT_EN
      e_miss = (t < 3) ? 4'd0 : ((t - 2 > 15) ? 4'd15 : 4'(t - 2));
`else
      e_miss = 4'd0;
`endif
      checks++;
      if (MissCount !== e_miss) begin
        failures++;
        $display("FAIL miss_tick%0d: got %0d expected %0d", t, MissCount, e_miss);
      end
      checks++;
      if (DueMask !== ((t == 1) ? 4'b0000 : 4'b0001)) begin
        failures++;
        $display("FAIL miss_tick%0d_duemask: got %b expected %b", t, DueMask, (t == 1) ? 4'b0000 : 4'b0001);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_schedule();
    test_timing();
    test_ack_collision();
    test_pending();
    test_reset_midscan();
    test_miss_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dose_schedule_reader.md
# dose_schedule_reader

Reads the per-medicine frequency table stored in RAM1 and counts each medicine's interval down in the timer's time units. It is the read side of the schedule that the reminder controller writes, and it sits between RAM1's read port, the timer's time-unit pulse and the LED/alert logic. It raises a per-medicine due flag that stays set until the controller acknowledges it. Optionally, it counts doses that came due again before being acknowledged (missed doses).

## Interface
- ID_W, 2, medicine-ID width; NUM_MEDS = 2**ID_W slots (4).
- FREQ_W, 4, width of frequency entry and per-slot countdown.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Tick  in  1  one-cycle pulse per time unit (timer output).
- R_en  out  1  RAM1 read enable, one cycle per slot.
- R_addr  out  ID_W  RAM1 read address (MedID).
- R_data  in  FREQ_W  RAM1 read data, valid the cycle after R_en.
- Ack  in  1  one-cycle acknowledge of a taken dose.
- AckId  in  ID_W  slot acknowledged, sampled with Ack.
- DueMask  out  NUM_MEDS  bit i = medicine i due.
- AnyDue  out  1  OR of DueMask.
- Busy  out  1  scan in progress.
- ScanDone  out  1  one-cycle pulse at end of scan.
- MissCount  out  4  saturating missed-dose total (0 unless macro enabled).

## Operation
- Reset (Rst=0, async):
  - all outputs 0; per-slot countdown regs 0; tick-pending 0; FSM IDLE.
  - Reset mid-scan aborts the scan immediately; R_en drops with reset.
- FSM: IDLE -> READ -> WAIT -> UPDATE -> (READ next slot | IDLE).
  - IDLE: Tick or pending=1 -> READ, slot=0, pending cleared.
  - READ: R_en=1, R_addr=slot.
  - WAIT: R_data captured into a register.
  - UPDATE: apply update rule; if slot==NUM_MEDS-1 -> IDLE with ScanDone=1, else slot+1 -> READ.
- Update rule per slot, with f=captured frequency and c=countdown:
  - f==0: c<=0, slot disabled, DueMask bit untouched.
  - c==0 (unloaded): c<=f, no due.
  - c==1: set DueMask[slot], c<=f.
  - otherwise: c<=c-1.
  - A frequency change takes effect at the next reload.
- Period: first Tick after load only loads the slot; thereafter due every f Ticks.
- Ack clears DueMask[AckId] on the next edge, in any state.
- Ack and set of the same bit in the same cycle: set wins.
- A Tick while Busy (including the UPDATE cycle) sets pending. Further Ticks while pending=1 are dropped.
- AnyDue is registered, coherent with DueMask.

## Timing
- Tick at cycle n (IDLE) -> R_en at n+1.
- Each slot takes 3 cycles; a full scan is 12 cycles.
- Slot i's DueMask change is visible 3i+4 cycles after Tick.
- ScanDone is asserted in the same cycle as slot 3's update; Busy=0 the following cycle.
- A pending tick restarts the scan (R_en) 2 cycles after ScanDone via IDLE.
- Busy=1 in READ/WAIT/UPDATE.
- R_addr holds its last value outside READ.

## Configuration
- DOSE_MISSED_COUNT_EN defined:
  - in UPDATE, setting a DueMask bit that is already 1 (and not being cleared by Ack that cycle) increments MissCount.
  - MissCount saturates at 15 and is cleared only by reset.
- Undefined: MissCount tied to 0 and no counter logic exists; all other behaviour is identical.

## Test plan
- Reset then RAM1 = {3,1,0,2}, Ticks: tick1 loads only, DueMask=0000. Tick2 -> 0010. Tick3 -> 1010. Tick4 -> 1011.
- Tick at cycle 10: R_en at 11,14,17,20 with R_addr 0..3. ScanDone at 22; Busy 11..22.
- Ack=1 with AckId=1 during slot-1 UPDATE that re-sets bit 1: bit stays 1. Ack on a later idle cycle clears it; AnyDue follows.
- Tick during scan plus a second Tick: exactly one extra scan starts 2 cycles after ScanDone; the second Tick is dropped.
- Rst low at mid-WAIT of slot 2: all outputs 0 asynchronously. After release, the first Tick reloads only, with no due.
- With DOSE_MISSED_COUNT_EN and freq 1 for slot 0, never acked: MissCount increments each Tick from the 3rd Tick, saturating at 15. Without the macro it stays 0.
